// File: rtl/lut_gate_pkg.sv
// Shared types, config selectors and the combine helper for lut_gate_pipe.
// One combine function keeps the stage-2 operator table in a single place.
package lut_gate_pkg;

  typedef enum logic [1:0] {
    XOR_OA = 2'd0,
    OR     = 2'd1,
    AND    = 2'd2,
    XNOR   = 2'd3
  } combine_mode_e;

  localparam logic [1:0] CFG_LUT_A = 2'd0;
  localparam logic [1:0] CFG_LUT_B = 2'd1;
  localparam logic [1:0] CFG_MODE  = 2'd2;
  localparam logic [1:0] CFG_CLR   = 2'd3;

  function automatic logic combine(
    input combine_mode_e m,
    input logic          a,
    input logic          b
  );
    logic r;
    r = 1'b0;
    case (m)
      XOR_OA:  r = (a | b) ^ (a & b);
      OR:      r = a | b;
      AND:     r = a & b;
      XNOR:    r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lut2_eval.sv
// Two-input programmable function: the truth table is indexed by {x,y}.
// Purely combinational; the top instantiates one per function per channel.
module lut2_eval (
  input  logic [3:0] i_lut,
  input  logic       i_x,
  input  logic       i_y,
  output logic       o_f
);

  logic [1:0] w_idx;

  assign w_idx = {i_x, i_y};
  assign o_f   = i_lut[w_idx];

endmodule

// File: rtl/lut_gate_pipe.sv
// N_CH-channel two-stage LUT gate pipeline with valid/ready flow control.
// Stage 1 holds a/b plus a mode snapshot; stage 2 holds the combined result.
module lut_gate_pipe
  import lut_gate_pkg::*;
#(
  parameter int         N_CH  = 4,
  parameter logic [3:0] LUT_A = 4'b0100,
  parameter logic [3:0] LUT_B = 4'b1001,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_CH-1:0]  in_x,
  input  logic [N_CH-1:0]  in_y,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [3:0]       cfg_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_CH-1:0]  out_z,
  output logic [CNT_W-1:0] beat_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]      r_lut_a;
  logic [3:0]      r_lut_b;
  combine_mode_e   r_mode;

  logic            r_v1;
  logic [N_CH-1:0] r_a;
  logic [N_CH-1:0] r_b;
  combine_mode_e   r_mode1;

  logic            r_v2;
  logic [N_CH-1:0] r_z;

  logic [CNT_W-1:0] r_cnt;

  logic            w_adv1;
  logic            w_adv2;
  logic            w_accept;
  logic            w_deliver;
  logic            w_clr;
  logic [N_CH-1:0] w_a;
  logic [N_CH-1:0] w_b;
  logic [N_CH-1:0] w_z;

  assign w_adv2    = out_ready | ~r_v2;
  assign w_adv1    = w_adv2 | ~r_v1;
  assign w_accept  = in_valid & w_adv1;
  assign w_deliver = r_v2 & out_ready;
  assign w_clr     = cfg_we & (cfg_sel == CFG_CLR);

  assign in_ready   = w_adv1;
  assign out_valid  = r_v2;
  assign out_z      = r_z;
  assign beat_count = r_cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    lut2_eval u_fa (
      .i_lut (r_lut_a),
      .i_x   (in_x[i]),
      .i_y   (in_y[i]),
      .o_f   (w_a[i])
    );
    lut2_eval u_fb (
      .i_lut (r_lut_b),
      .i_x   (in_x[i]),
      .i_y   (in_y[i]),
      .o_f   (w_b[i])
    );
    assign w_z[i] = combine(r_mode1, r_a[i], r_b[i]);
  end

  // Config registers; a beat accepted on the write edge still sees old values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_lut_a <= LUT_A;
      r_lut_b <= LUT_B;
      r_mode  <= XOR_OA;
    end else if (cfg_we) begin
      case (cfg_sel)
        CFG_LUT_A: r_lut_a <= cfg_data;
        CFG_LUT_B: r_lut_b <= cfg_data;
        CFG_MODE:  r_mode  <= combine_mode_e'(cfg_data[1:0]);
        default:   ;
      endcase
    end
  end

  // Stage 1: evaluate both functions and snapshot the mode on accept.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_v1    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_mode1 <= XOR_OA;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (w_accept) begin
        r_a     <= w_a;
        r_b     <= w_b;
        r_mode1 <= r_mode;
      end
    end
  end

  // Stage 2: combine; result is frozen while the consumer stalls.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_v2 <= 1'b0;
      r_z  <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_z <= w_z;
      end
    end
  end

  // Saturating delivered-beat counter; a clear wins over a same-edge delivery.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_cnt <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
    end else if (w_deliver && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
